vscale_hasti_bridge_master: RTL and testbench

- HASTI (AHB-lite) initiator.
- Converts a simple valid/ready request stream plus a registered response strobe into pipelined single transfers on a HASTI master port.
- Sits between a client (DMA engine, debug port, test driver) and any HASTI slave such as the dual-port SRAM.
- Handles byte-lane steering, wait states, two-cycle ERROR responses and local misalignment faults.

---
 rtl/vscale_hasti_bridge_master.sv | 198 +++++++++++++++++++
 tb/tb_vscale_hasti_bridge_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_bridge_master.sv
// HASTI (AHB-lite) initiator: turns a valid/ready request stream into
// pipelined single transfers and returns a registered one-cycle response
// per accepted request, with byte-lane steering and error accounting.
module vscale_hasti_bridge_master #(
   parameter logic [3:0] HPROT    = 4'b0011,
   parameter int          ERRCNT_W = 16
) (
   input  logic                hclk,
   input  logic                hresetn,
   // client request stream
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_addr,
   input  logic                req_write,
   input  logic [2:0]          req_size,
   input  logic [31:0]         req_wdata,
   // registered response strobe
   output logic                resp_valid,
   output logic                resp_write,
   output logic                resp_err,
   output logic [31:0]         resp_rdata,
   output logic [ERRCNT_W-1:0] err_count,
   // HASTI master port
   output logic [31:0]         haddr,
   output logic                hwrite,
   output logic [2:0]          hsize,
   output logic [2:0]          hburst,
   output logic                hmastlock,
   output logic [3:0]          hprot,
   output logic [1:0]          htrans,
   output logic [31:0]         hwdata,
   input  logic [31:0]         hrdata,
   input  logic                hready,
   input  logic                hresp,
   // FSM state for observation
   output logic [1:0]          dbg_state
);

   // Handshake: a request transfers on a rising hclk edge where
   // req_valid && req_ready; the client holds it stable until then.
   // Responses are a one-cycle resp_valid strobe with no backpressure.

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_ERR  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic                 aligned;
   logic                 accept;
   logic                 complete;
   logic                 complete_err;
   logic [31:0]          wdata_rep;
   logic [31:0]          rdata_shifted;
   logic [31:0]          rdata_steered;
   logic [31:0]          resp_rdata_d;

   logic [1:0]           dp_addr_q;
   logic [2:0]           dp_size_q;
   logic                 dp_write_q;
   logic                 dp_misaligned_q;
   logic [31:0]          dp_wdata_q;

   logic                 resp_valid_q;
   logic                 resp_write_q;
   logic                 resp_err_q;
   logic [31:0]          resp_rdata_q;
   logic [ERRCNT_W-1:0]  err_count_q;

   // Natural alignment check; sizes above word are treated as word.
   always_comb begin
      case (req_size)
         3'd0:    aligned = 1'b1;
         3'd1:    aligned = ~req_addr[0];
         default: aligned = (req_addr[1:0] == 2'b00);
      endcase
   end

   // The second ERROR cycle blocks new address phases, so the pending
   // request stays with the client until the error has completed.
   assign req_ready = hresetn & hready & (state_q != S_ERR);
   assign accept    = req_valid & req_ready;

   // Address phase passes straight through; misaligned requests never
   // reach the bus and are faulted locally in their data phase.
   assign haddr     = req_addr;
   assign hwrite    = req_write;
   assign hsize     = req_size;
   assign htrans    = (hresetn && req_valid && aligned && (state_q != S_ERR))
                      ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign hburst    = 3'b000;
   assign hmastlock = 1'b0;
   assign hprot     = HPROT;
   assign hwdata    = dp_wdata_q;

   // Replicate narrow write data across all byte lanes.
   always_comb begin
      case (req_size)
         3'd0:    wdata_rep = {4{req_wdata[7:0]}};
         3'd1:    wdata_rep = {2{req_wdata[15:0]}};
         default: wdata_rep = req_wdata;
      endcase
   end

   // Next-state logic and data-phase completion detection.
   always_comb begin
      state_d      = state_q;
      complete     = 1'b0;
      complete_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_DATA;
         end
         S_DATA: begin
            if (hready) begin
               complete     = 1'b1;
               complete_err = hresp | dp_misaligned_q;
               state_d      = accept ? S_DATA : S_IDLE;
            end else if (hresp) begin
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            // second cycle of a two-cycle ERROR: always an error completion
            if (hready) begin
               complete     = 1'b1;
               complete_err = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read steering: move the addressed lane to bit 0 and trim to size.
   always_comb begin
      rdata_shifted = hrdata >> {dp_addr_q, 3'b000};
      case (dp_size_q)
         3'd0:    rdata_steered = {24'd0, rdata_shifted[7:0]};
         3'd1:    rdata_steered = {16'd0, rdata_shifted[15:0]};
         default: rdata_steered = rdata_shifted;
      endcase
      resp_rdata_d = (complete && !complete_err && !dp_write_q) ? rdata_steered : 32'd0;
   end

   // State register.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Data-phase registers, loaded when a request is accepted.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dp_addr_q       <= 2'd0;
         dp_size_q       <= 3'd0;
         dp_write_q      <= 1'b0;
         dp_misaligned_q <= 1'b0;
         dp_wdata_q      <= 32'd0;
      end else if (accept) begin
         dp_addr_q       <= req_addr[1:0];
         dp_size_q       <= req_size;
         dp_write_q      <= req_write;
         dp_misaligned_q <= ~aligned;
         dp_wdata_q      <= wdata_rep;
      end
   end

   // Registered response strobe and saturating error counter.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         resp_valid_q <= 1'b0;
         resp_write_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         err_count_q  <= '0;
      end else begin
         resp_valid_q <= complete;
         resp_write_q <= complete & dp_write_q;
         resp_err_q   <= complete & complete_err;
         resp_rdata_q <= resp_rdata_d;
         if (complete && complete_err && (err_count_q != {ERRCNT_W{1'b1}}))
            err_count_q <= err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_write = resp_write_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign err_count  = err_count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_vscale_hasti_bridge_master.sv
// Bench for vscale_hasti_bridge_master: a byte-array reference model predicts
// every response, a scripted HASTI slave serves transfers with planned wait
// states and errors, and a monitor pops expectations on each resp_valid.
module tb_vscale_hasti_bridge_master;

   // ---------------- clock / reset / DUT ----------------
   logic        hclk = 1'b0;
   logic        hresetn;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        resp_valid, resp_write, resp_err;
   logic [31:0] resp_rdata;
   logic [15:0] err_count;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hmastlock, hready, hresp;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans, dbg_state;

   always #5 hclk = ~hclk;

   vscale_hasti_bridge_master dut (
      .hclk(hclk), .hresetn(hresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_write(resp_write), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .err_count(err_count),
      .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
      .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp), .dbg_state(dbg_state)
   );

   // ---------------- shared bench state ----------------
   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      logic        wr;
      logic [31:0] hw;
      int          waits;
      logic        err;
   } plan_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          exp_errcnt = 0;
   logic [7:0]  model_mem [64];
   logic [7:0]  slave_mem [64];
   plan_t       plan_q [$];
   // {resp cycle[31:0], write, err, rdata[31:0]}
   logic [65:0] exp_q [$];
   plan_t       s_plan;
   bit          s_active = 1'b0;
   int          s_waits = 0;
   int          s_err_stage = 0;

   always @(posedge hclk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nbytes(input logic [2:0] s);
      return (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
   endfunction

   // Little-endian read of n bytes from the reference memory.
   function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < n; i++)
         v = v | (32'(model_mem[(int'(addr[5:0]) + i) % 64]) << (8 * i));
      return v;
   endfunction

   task automatic preload(input logic [31:0] addr, input logic [31:0] word);
      for (int i = 0; i < 4; i++) begin
         model_mem[(int'(addr[5:0]) + i) % 64] = word[8*i +: 8];
         slave_mem[(int'(addr[5:0]) + i) % 64] = word[8*i +: 8];
      end
   endtask

   // ---------------- driver ----------------
   task automatic issue(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                        input logic [31:0] wdata, input int waits, input logic err);
      int          n;
      int          t;
      logic        al;
      logic        e_err;
      logic [31:0] e_rd;
      logic [31:0] hw;
      plan_t       p;
      bit          acc;
      n     = nbytes(size);
      al    = ((addr % n) == 0);
      e_err = !al || err;
      for (int l = 0; l < 4; l++) hw[8*l +: 8] = wdata[8*(l % n) +: 8];
      e_rd = 32'd0;
      if (!e_err && !wr) e_rd = model_read(addr, n);
      if (!e_err && wr)
         for (int i = 0; i < n; i++) model_mem[(int'(addr[5:0]) + i) % 64] = wdata[8*i +: 8];
      if (al) begin
         p.addr = addr; p.size = size; p.wr = wr; p.hw = hw; p.waits = waits; p.err = err;
         plan_q.push_back(p);
      end
      @(negedge hclk);
      req_valid = 1'b1; req_addr = addr; req_size = size; req_write = wr; req_wdata = wdata;
      acc = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) begin
         if (k > 0) @(negedge hclk);
         #4;
         chk("haddr", haddr, addr);
         if (!al) chk("htrans_misaligned", 32'(htrans), 32'd0);
         else if (req_ready) chk("htrans_nonseq", 32'(htrans), 32'd2);
         if (req_ready) begin
            acc = 1'b1;
            t = cyc + 1 + (al ? (waits + (err ? 2 : 1)) : 1);
            exp_q.push_back({t[31:0], wr, e_err, e_rd});
         end
      end
      if (!acc) begin
         n_checks++; n_errors++;
         $display("FAIL accept_timeout: req_ready stayed 0, expected acceptance for addr 0x%08h", addr);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge hclk);
         req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge hclk);
      if (exp_q.size() != 0) begin
         n_checks++; n_errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   // ---------------- scripted HASTI slave ----------------
   initial begin : slave
      int a4;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
      forever begin
         @(negedge hclk);
         #1;
         if (s_active && s_waits > 0) begin
            hready = 1'b0; hresp = 1'b0; hrdata = $urandom;
         end else if (s_active && s_plan.err) begin
            hready = (s_err_stage == 1); hresp = 1'b1; hrdata = $urandom;
         end else if (s_active && !s_plan.wr) begin
            a4 = int'(s_plan.addr[5:2]) * 4;
            hready = 1'b1; hresp = 1'b0;
            hrdata = {slave_mem[a4+3], slave_mem[a4+2], slave_mem[a4+1], slave_mem[a4]};
         end else begin
            hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
         end
         #3;
         if (s_active && s_plan.err && s_err_stage == 1)
            chk("htrans_in_err", 32'(htrans), 32'd0);
         if (s_active) begin
            if (s_plan.wr) chk("hwdata", hwdata, s_plan.hw);
            if (!hready) begin
               if (s_waits > 0) s_waits--;
               else s_err_stage = 1;
            end else begin
               if (s_plan.wr && !s_plan.err)
                  for (int i = 0; i < nbytes(s_plan.size); i++)
                     slave_mem[(int'(s_plan.addr[5:0]) + i) % 64] =
                        hwdata[8*((int'(s_plan.addr[1:0]) + i) % 4) +: 8];
               s_active = 1'b0;
            end
         end
         if (hready && htrans == 2'b10) begin
            if (plan_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_transfer: NONSEQ at 0x%08h, expected no transfer", haddr);
            end else begin
               s_plan = plan_q.pop_front();
               chk("bus_addr", haddr, s_plan.addr);
               chk("bus_hwrite", 32'(hwrite), 32'(s_plan.wr));
               chk("bus_hsize", 32'(hsize), 32'(s_plan.size));
               s_active    = 1'b1;
               s_waits     = s_plan.waits;
               s_err_stage = 0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [65:0] e;
      forever begin
         @(posedge hclk);
         #1;
         if (hresetn && resp_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_resp: resp_valid=1, expected no response (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("resp_write", 32'(resp_write), 32'(e[33]));
               chk("resp_err", 32'(resp_err), 32'(e[32]));
               chk("resp_rdata", resp_rdata, e[31:0]);
               chk("resp_cycle", 32'(cyc), e[65:34]);
               if (e[32]) exp_errcnt++;
               chk("err_count", 32'(err_count), 32'(exp_errcnt));
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [31:0] a, wd;
      logic [2:0]  sz;
      logic        wr, e;
      int          n, w;
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = 8'($urandom);
         slave_mem[i] = model_mem[i];
      end
      hresetn = 1'b0;
      req_valid = 1'b1; req_addr = 32'h104; req_size = 3'd2; req_write = 1'b0; req_wdata = 32'd0;

      // outputs while reset is held
      @(posedge hclk);
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_htrans", 32'(htrans), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("hburst", 32'(hburst), 32'd0);
      chk("hmastlock", 32'(hmastlock), 32'd0);
      chk("hprot", 32'(hprot), 32'h3);
      repeat (2) @(negedge hclk);
      req_valid = 1'b0;
      hresetn = 1'b1;

      // directed cases
      preload(32'h104, 32'hDEADBEEF);
      issue(32'h104, 3'd2, 1'b0, 32'd0, 0, 1'b0);
      issue(32'h203, 3'd0, 1'b1, 32'h0000000A, 0, 1'b0);
      issue(32'h203, 3'd0, 1'b0, 32'd0, 0, 1'b0);
      issue(32'h0, 3'd2, 1'b0, 32'd0, 0, 1'b0);
      issue(32'h4, 3'd2, 1'b0, 32'd0, 2, 1'b0);
      issue(32'h8, 3'd2, 1'b0, 32'd0, 0, 1'b0);
      issue(32'h1000, 3'd2, 1'b1, 32'h12345678, 0, 1'b1);
      issue(32'h20, 3'd2, 1'b0, 32'd0, 0, 1'b0);
      issue(32'h101, 3'd1, 1'b0, 32'd0, 0, 1'b0);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         sz = 3'($urandom_range(0, 3));
         n  = nbytes(sz);
         a  = 32'($urandom_range(0, 32'h3FFF));
         if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
         wr = 1'($urandom_range(0, 1));
         wd = $urandom;
         w  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         e  = ((a % n) == 0) && ($urandom_range(0, 9) == 0);
         issue(a, sz, wr, wd, w, e);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
      drain();

      // reset in the middle of a waited data phase
      issue(32'h10, 3'd2, 1'b0, 32'd0, 3, 1'b0);
      @(negedge hclk);
      req_valid = 1'b0;
      #2;
      hresetn = 1'b0;
      #1;
      chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
      chk("mid_rst_resp_write", 32'(resp_write), 32'd0);
      chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      chk("mid_rst_htrans", 32'(htrans), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      exp_q.delete();
      plan_q.delete();
      s_active = 1'b0;
      exp_errcnt = 0;
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;
      repeat (8) @(negedge hclk);
      chk("post_rst_err_count", 32'(err_count), 32'd0);
      chk("post_rst_state", 32'(dbg_state), 32'd0);

      // recovery after reset
      issue(32'h104, 3'd2, 1'b0, 32'd0, 0, 1'b0);
      issue(32'h106, 3'd1, 1'b0, 32'd0, 1, 1'b0);
      idle(1);
      drain();
      repeat (3) @(negedge hclk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
